// File: rtl/proc_dispatch_sched.sv
// rtl/proc_dispatch_sched.sv - arbitration FIFO read side, frame dispatcher to the image engine
module proc_dispatch_sched #(
   parameter int DW = 32,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] frame_len,
   input  logic          cmplt_clr,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_dout_data,
   input  logic [1:0]    fifo_dout_mode,
   input  logic [7:0]    fifo_dout_proc_val,
   input  logic          fifo_dout_src,
   output logic          fifo_rd_en,
   output logic          eng_valid,
   input  logic          eng_ready,
   output logic [DW-1:0] eng_data,
   output logic [1:0]    eng_mode,
   output logic [7:0]    eng_proc_val,
   output logic          eng_last,
   output logic          mstr_cmplt,
   output logic          busy,
   output logic          src_err,
   output logic [LW-1:0] word_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          eng_valid_q, eng_valid_d;
   logic [DW-1:0] eng_data_q, eng_data_d;
   logic [1:0]    eng_mode_q, eng_mode_d;
   logic [7:0]    eng_proc_val_q, eng_proc_val_d;
   logic          eng_last_q, eng_last_d;
   logic          mstr_cmplt_q, mstr_cmplt_d;
   logic          busy_q, busy_d;
   logic          src_err_q, src_err_d;
   logic          src_q, src_d;
   logic [LW-1:0] word_cnt_q, word_cnt_d;
   logic [LW-1:0] len_q, len_d;
   logic          slot_free;
   logic          pop;
   logic [LW-1:0] cnt_inc;

   // Next-state and datapath: pop when the output slot is free, drop idle entries, close the frame on the last word
   always_comb begin
      state_d        = state_q;
      eng_valid_d    = eng_valid_q;
      eng_data_d     = eng_data_q;
      eng_mode_d     = eng_mode_q;
      eng_proc_val_d = eng_proc_val_q;
      eng_last_d     = eng_last_q;
      mstr_cmplt_d   = mstr_cmplt_q;
      src_err_d      = src_err_q;
      src_d          = src_q;
      word_cnt_d     = word_cnt_q;
      len_d          = len_q;
      slot_free      = !eng_valid_q || eng_ready;
      pop            = (state_q == S_RUN) && !fifo_empty && slot_free;
      cnt_inc        = word_cnt_q + LW'(1);

      case (state_q)
         S_IDLE: begin
            if (start && (frame_len != '0)) begin
               state_d    = S_RUN;
               len_d      = frame_len;
               word_cnt_d = '0;
               src_err_d  = 1'b0;
               src_d      = 1'b0;
            end
         end
         S_RUN: begin
            if (eng_valid_q && eng_ready) begin
               eng_valid_d = 1'b0;
            end
            if (pop && (fifo_dout_mode != 2'b00)) begin
               eng_valid_d    = 1'b1;
               eng_data_d     = fifo_dout_data;
               eng_mode_d     = fifo_dout_mode;
               eng_proc_val_d = fifo_dout_proc_val;
               eng_last_d     = (cnt_inc == len_q);
               word_cnt_d     = cnt_inc;
               if (word_cnt_q == '0) begin
                  src_d = fifo_dout_src;
               end else if (fifo_dout_src != src_q) begin
                  src_err_d = 1'b1;
               end
               if (cnt_inc == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (eng_valid_q && eng_ready) begin
               eng_valid_d  = 1'b0;
               eng_last_d   = 1'b0;
               mstr_cmplt_d = 1'b1;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            if (cmplt_clr) begin
               mstr_cmplt_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
   end

   // State and output registers; reset abandons any frame in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         eng_valid_q    <= 1'b0;
         eng_data_q     <= '0;
         eng_mode_q     <= '0;
         eng_proc_val_q <= '0;
         eng_last_q     <= 1'b0;
         mstr_cmplt_q   <= 1'b0;
         busy_q         <= 1'b0;
         src_err_q      <= 1'b0;
         src_q          <= 1'b0;
         word_cnt_q     <= '0;
         len_q          <= '0;
      end else begin
         state_q        <= state_d;
         eng_valid_q    <= eng_valid_d;
         eng_data_q     <= eng_data_d;
         eng_mode_q     <= eng_mode_d;
         eng_proc_val_q <= eng_proc_val_d;
         eng_last_q     <= eng_last_d;
         mstr_cmplt_q   <= mstr_cmplt_d;
         busy_q         <= busy_d;
         src_err_q      <= src_err_d;
         src_q          <= src_d;
         word_cnt_q     <= word_cnt_d;
         len_q          <= len_d;
      end
   end

   assign fifo_rd_en   = pop;
   assign eng_valid    = eng_valid_q;
   assign eng_data     = eng_data_q;
   assign eng_mode     = eng_mode_q;
   assign eng_proc_val = eng_proc_val_q;
   assign eng_last     = eng_last_q;
   assign mstr_cmplt   = mstr_cmplt_q;
   assign busy         = busy_q;
   assign src_err      = src_err_q;
   assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_proc_dispatch_sched.sv
// tb/tb_proc_dispatch_sched.sv - scoreboard bench for proc_dispatch_sched
module tb_proc_dispatch_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] frame_len;
   logic        cmplt_clr;
   logic        fifo_empty;
   logic [31:0] fifo_dout_data;
   logic [1:0]  fifo_dout_mode;
   logic [7:0]  fifo_dout_proc_val;
   logic        fifo_dout_src;
   logic        fifo_rd_en;
   logic        eng_valid;
   logic        eng_ready;
   logic [31:0] eng_data;
   logic [1:0]  eng_mode;
   logic [7:0]  eng_proc_val;
   logic        eng_last;
   logic        mstr_cmplt;
   logic        busy;
   logic        src_err;
   logic [15:0] word_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [42:0] mem [0:63];
   logic [5:0]  rd_ptr;
   logic [5:0]  wr_ptr;
   logic [42:0] exp_q [$];

   proc_dispatch_sched #(.DW(32), .LW(16)) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .cmplt_clr(cmplt_clr),
      .fifo_empty(fifo_empty), .fifo_dout_data(fifo_dout_data), .fifo_dout_mode(fifo_dout_mode),
      .fifo_dout_proc_val(fifo_dout_proc_val), .fifo_dout_src(fifo_dout_src),
      .fifo_rd_en(fifo_rd_en), .eng_valid(eng_valid), .eng_ready(eng_ready),
      .eng_data(eng_data), .eng_mode(eng_mode), .eng_proc_val(eng_proc_val),
      .eng_last(eng_last), .mstr_cmplt(mstr_cmplt), .busy(busy), .src_err(src_err),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // first-word-fall-through FIFO model
   assign fifo_empty         = (rd_ptr == wr_ptr);
   assign fifo_dout_data     = mem[rd_ptr][31:0];
   assign fifo_dout_mode     = mem[rd_ptr][33:32];
   assign fifo_dout_proc_val = mem[rd_ptr][41:34];
   assign fifo_dout_src      = mem[rd_ptr][42];

   always @(posedge clk or posedge rst) begin
      if (rst) rd_ptr <= '0;
      else if (fifo_rd_en) rd_ptr <= rd_ptr + 6'd1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard: every handshake must match the next expected word
   always @(negedge clk) begin
      if (!rst && eng_valid && eng_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(eng_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check("dispatch", 64'({eng_data, eng_mode, eng_proc_val, eng_last}), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] d, input logic [1:0] m, input logic [7:0] pv,
                            input logic s, input logic last);
      mem[wr_ptr] = {s, pv, m, d};
      wr_ptr = wr_ptr + 6'd1;
      if (m != 2'b00) exp_q.push_back({d, m, pv, last});
   endtask

   task automatic start_frame(input logic [15:0] len);
      frame_len = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!mstr_cmplt && n < budget) begin
         tick();
         n++;
      end
      check("done_timeout", 64'(mstr_cmplt), 64'd1);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!eng_valid && n < budget) begin
         tick();
         n++;
      end
      check("valid_timeout", 64'(eng_valid), 64'd1);
   endtask

   task automatic clear_done();
      cmplt_clr = 1'b1;
      tick();
      cmplt_clr = 1'b0;
   endtask

   initial begin
      logic [5:0] pat;
      rst = 1'b1; start = 1'b0; frame_len = '0; cmplt_clr = 1'b0; eng_ready = 1'b1; wr_ptr = '0;
      tick(); tick();
      check("rst_valid", 64'(eng_valid), 64'd0);
      check("rst_cmplt", 64'(mstr_cmplt), 64'd0);
      check("rst_cnt", 64'(word_cnt), 64'd0);
      rst = 1'b0;
      tick();

      // basic frame at full throughput
      for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), 2'b01, 8'(i + 1), 1'b0, i == 3);
      start_frame(16'd4);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat[i] = eng_valid;
         tick();
      end
      check("valid_pattern", 64'(pat), 64'b011110);
      check("cmplt_after_frame", 64'(mstr_cmplt), 64'd1);
      check("src_err_clean", 64'(src_err), 64'd0);
      check("cnt_final", 64'(word_cnt), 64'd4);
      check("busy_done", 64'(busy), 64'd0);

      // start during DONE ignored, clear returns to IDLE
      start_frame(16'd4);
      tick();
      check("start_in_done_busy", 64'(busy), 64'd0);
      check("start_in_done_cmplt", 64'(mstr_cmplt), 64'd1);
      check("start_in_done_cnt", 64'(word_cnt), 64'd4);
      clear_done();
      check("clr_cmplt", 64'(mstr_cmplt), 64'd0);

      // zero-length start ignored
      start_frame(16'd0);
      check("zero_len_busy", 64'(busy), 64'd0);
      tick();
      check("zero_len_rd", 64'(fifo_rd_en), 64'd0);

      // engine stall on second word
      for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), 2'b01, 8'h10 + 8'(i), 1'b0, i == 3);
      eng_ready = 1'b0;
      start_frame(16'd4);
      wait_valid(20);
      eng_ready = 1'b1;
      tick();
      eng_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_data", 64'(eng_data), 64'hA1);
         check("stall_rd_en", 64'(fifo_rd_en), 64'd0);
         tick();
      end
      eng_ready = 1'b1;
      wait_done(40);
      check("stall_cnt", 64'(word_cnt), 64'd4);
      clear_done();

      // idle entry dropped
      push_word(32'hB0, 2'b01, 8'h21, 1'b0, 1'b0);
      push_word(32'hB1, 2'b00, 8'h22, 1'b0, 1'b0);
      push_word(32'hB2, 2'b10, 8'h23, 1'b0, 1'b1);
      start_frame(16'd2);
      wait_done(40);
      check("idle_cnt", 64'(word_cnt), 64'd2);
      check("idle_fifo_drained", 64'(fifo_empty), 64'd1);
      clear_done();

      // mixed sources
      push_word(32'hD0, 2'b01, 8'h31, 1'b0, 1'b0);
      push_word(32'hD1, 2'b11, 8'h32, 1'b1, 1'b0);
      push_word(32'hD2, 2'b01, 8'h33, 1'b0, 1'b1);
      eng_ready = 1'b0;
      start_frame(16'd3);
      wait_valid(20);
      eng_ready = 1'b1;
      for (int n = 0; n < 20 && word_cnt != 16'd2; n++) tick();
      @(negedge clk);
      check("src_err_second", 64'(src_err), 64'd1);
      wait_done(40);
      check("src_err_done", 64'(src_err), 64'd1);
      clear_done();
      push_word(32'hE0, 2'b01, 8'h41, 1'b1, 1'b1);
      start_frame(16'd1);
      check("src_err_cleared", 64'(src_err), 64'd0);
      wait_done(40);
      clear_done();

      // async reset mid-frame, then a clean frame
      for (int i = 0; i < 4; i++) push_word(32'hC0 + 32'(i), 2'b01, 8'h50, 1'b0, i == 3);
      eng_ready = 1'b0;
      start_frame(16'd4);
      wait_valid(20);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 64'(eng_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_data", 64'(eng_data), 64'd0);
      check("arst_cnt", 64'(word_cnt), 64'd0);
      check("arst_rd_en", 64'(fifo_rd_en), 64'd0);
      exp_q.delete();
      wr_ptr = '0;
      tick();
      rst = 1'b0;
      eng_ready = 1'b1;
      push_word(32'hF0, 2'b01, 8'h61, 1'b1, 1'b0);
      push_word(32'hF1, 2'b10, 8'h62, 1'b1, 1'b1);
      start_frame(16'd2);
      wait_done(40);
      check("post_rst_cnt", 64'(word_cnt), 64'd2);
      check("post_rst_src_err", 64'(src_err), 64'd0);
      clear_done();

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/proc_dispatch_sched.md
Name: proc_dispatch_sched

Overview:
- Read-side controller for the arbitration FIFO: pops entries written by the slave arbiter and dispatches them to the image processing engine over a valid/ready handshake.
- Sequences one frame of `frame_len` words per `start`, drops idle (mode 00) entries, and raises `mstr_cmplt` at frame end so the arbiter stops granting.
- Flags any frame that mixes data from both sources.

Parameters:
- DW, 32, pixel data word width
- LW, 16, width of frame length / word counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a frame (accepted only in IDLE)
- frame_len  in  LW  words per frame, sampled on accepted start
- cmplt_clr  in  1  acknowledges completion; DONE -> IDLE
- fifo_empty  in  1  FIFO empty flag (first-word-fall-through FIFO)
- fifo_dout_data  in  DW  head entry data
- fifo_dout_mode  in  2  head entry mode
- fifo_dout_proc_val  in  8  head entry processing value
- fifo_dout_src  in  1  head entry source (0 = slave0, 1 = slave1)
- fifo_rd_en  out  1  pop head entry this cycle
- eng_valid  out  1  engine output word valid
- eng_ready  in  1  engine accepts word
- eng_data  out  DW  word to engine
- eng_mode  out  2  mode of word
- eng_proc_val  out  8  processing value of word
- eng_last  out  1  marks final word of frame
- mstr_cmplt  out  1  frame complete, level, held until cmplt_clr
- busy  out  1  state is RUN or DRAIN
- src_err  out  1  sticky; frame contained both sources
- word_cnt  out  LW  words dispatched in current frame

Behaviour:
- Reset (async, rst=1): state IDLE; `fifo_rd_en`, `eng_valid`, `eng_last`, `mstr_cmplt`, `busy`, `src_err` = 0; `eng_data`/`eng_mode`/`eng_proc_val` = 0; `word_cnt` = 0; internal length/source registers = 0. Reset mid-frame abandons the frame with no completion.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` with `frame_len`≠0 -> RUN; latch `frame_len`; clear `word_cnt` and `src_err`.
  - `start` with `frame_len`=0 is ignored; state stays IDLE.
- RUN:
  - Slot free = !`eng_valid` | `eng_ready`.
  - `fifo_rd_en` = RUN & !`fifo_empty` & slot free (combinational).
  - On a pop with mode≠00: next cycle `eng_valid`=1 and `eng_*` are loaded from the head entry; `word_cnt`+1.
  - On a pop with mode=00: entry discarded; `eng_valid` falls if it was being consumed; count unchanged.
  - First counted word latches its source. Any later counted word with a different source sets `src_err` (sticky until the next accepted start).
  - The word that makes `word_cnt` equal the latched length is loaded with `eng_last`=1; same edge -> DRAIN. No further pops.
- DRAIN: hold `eng_*` until `eng_valid` & `eng_ready`; then `eng_valid`=0, `eng_last`=0, `mstr_cmplt`=1, -> DONE.
- DONE: `mstr_cmplt` held at 1; `start` ignored; `cmplt_clr` -> IDLE with `mstr_cmplt`=0 next cycle. `word_cnt` holds its final value until the next accepted start.
- `cmplt_clr` outside DONE: no effect.
- Latency: FIFO head to `eng_valid` = 1 cycle. Sustained throughput is 1 word/cycle with `eng_ready` held high and the FIFO non-empty.
- `eng_*` must remain stable while `eng_valid` & !`eng_ready`.
- `eng_valid` never deasserts without a handshake, except on reset.
- `word_cnt` is LW bits and saturates at the latched length; there is no wrap.
- `busy` = state is RUN or DRAIN (registered).

Test Plan:
- Reset, `start` with `frame_len`=4, FIFO holds 4 slave0 words 0xA0..0xA3 mode 01, `eng_ready`=1 -> 4 consecutive `eng_valid` cycles starting 1 cycle after `start`+1; `eng_last` on 0xA3; `mstr_cmplt`=1 next cycle; `src_err`=0.
- Same frame with `eng_ready` low for 3 cycles on word 2 -> `eng_data` held at 0xA1, `fifo_rd_en`=0 during the stall; no word lost or duplicated.
- FIFO sequence: mode 01, mode 00, mode 10, `frame_len`=2 -> mode 00 entry popped but not dispatched; `word_cnt` ends at 2; frame completes.
- `frame_len`=3, sources 0,1,0 -> `src_err`=1 after the second word and still 1 in DONE; the next accepted `start` clears it.
- `start` with `frame_len`=0, and `start` during DONE -> both ignored. `cmplt_clr` in DONE -> IDLE, `mstr_cmplt`=0 next cycle.
- Assert `rst` in RUN with `eng_valid`=1 -> all outputs 0 immediately (async). After release, a new `start` runs a clean frame.
